// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: master-port and slave-port bundle around the round-robin arbiter
interface bus_arbiter_rr_if #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES = 4
);
  logic [N_MASTERS-1:0] m_breq, m_bgrant;
  logic [N_MASTERS-1:0] m_mode, m_wr_bus, m_master_valid, m_master_ready;
  logic [N_MASTERS-1:0] m_rd_bus, m_ack, m_slave_ready, m_slave_valid;
  logic [N_SLAVES-1:0] s_mode, s_wr_bus, s_master_valid, s_master_ready;
  logic [N_SLAVES-1:0] s_rd_bus, s_slave_ready, s_slave_valid;
  logic [2:0] owner;
  logic timeout_pulse;
  modport slave (
    input m_breq, m_mode, m_wr_bus, m_master_valid, m_master_ready,
    input s_rd_bus, s_slave_ready, s_slave_valid,
    output m_bgrant, m_rd_bus, m_ack, m_slave_ready, m_slave_valid,
    output s_mode, s_wr_bus, s_master_valid, s_master_ready, owner, timeout_pulse
  );
  modport master (
    output m_breq, m_mode, m_wr_bus, m_master_valid, m_master_ready,
    output s_rd_bus, s_slave_ready, s_slave_valid,
    input m_bgrant, m_rd_bus, m_ack, m_slave_ready, m_slave_valid,
    input s_mode, s_wr_bus, s_master_valid, s_master_ready, owner, timeout_pulse
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter connecting one master at a time to a serially addressed slave
module bus_arbiter_rr #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES = 4,
  parameter int ADDR_BITS = 5,
  parameter int SEL_BITS = 2,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  bus_arbiter_rr_if.slave bus
);
  localparam int CW = $clog2(ADDR_BITS + 1);
  localparam int IW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, GRANT, ADDR, CONNECTED, CLEAN} state_t;
  state_t state;
  logic [2:0] owner, last_owner, win;
  logic [ADDR_BITS-1:0] addr, addr_nxt;
  logic [SEL_BITS-1:0] sel, sel_nxt;
  logic [CW-1:0] bit_cnt;
  logic [IW-1:0] idle_cnt;
  logic tp, live, granted, conn;
  logic breq, mode, wr, mvalid, mready, rd, sready, svalid, hs;
  int best, d;
  // owner's and selected slave's signals, next address, and the round-robin winner
  always_comb begin
    {breq, mode, wr, mvalid, mready, rd, sready, svalid} = '0;
    win = '0;
    best = N_MASTERS;
    d = 0;
    for (int j = 0; j < N_MASTERS; j++) begin
      d = (j + 2 * N_MASTERS - 1 - int'(last_owner)) % N_MASTERS;
      if (bus.m_breq[j] && d < best) begin
        best = d;
        win = 3'(j);
      end
      if (int'(owner) == j) begin
        breq = bus.m_breq[j];
        mode = bus.m_mode[j];
        wr = bus.m_wr_bus[j];
        mvalid = bus.m_master_valid[j];
        mready = bus.m_master_ready[j];
      end
    end
    for (int i = 0; i < N_SLAVES; i++) begin
      if (int'(sel) == i) begin
        rd = bus.s_rd_bus[i];
        sready = bus.s_slave_ready[i];
        svalid = bus.s_slave_valid[i];
      end
    end
    hs = (mvalid & sready) | (svalid & mready);
    addr_nxt = ADDR_BITS'({addr, wr});
    sel_nxt = addr_nxt[ADDR_BITS-1 -: SEL_BITS];
  end
  // arbitration, serial address capture, idle watchdog and release sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last_owner <= 3'(N_MASTERS - 1);
      addr <= '0;
      sel <= '0;
      bit_cnt <= '0;
      idle_cnt <= '0;
      tp <= 1'b0;
    end else begin
      tp <= 1'b0;
      case (state)
        IDLE: if (|bus.m_breq) begin
          owner <= win;
          state <= GRANT;
        end
        GRANT: if (!breq) state <= IDLE;
          else if (mvalid) begin
            last_owner <= owner;
            state <= ADDR;
          end
        ADDR: if (!breq) state <= CLEAN;
          else if (mvalid) begin
            addr <= addr_nxt;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(ADDR_BITS - 1)) begin
              sel <= sel_nxt;
              state <= int'(sel_nxt) < N_SLAVES ? CONNECTED : CLEAN;
            end
          end
        CONNECTED: if (!breq) state <= CLEAN;
          else if (hs) idle_cnt <= '0;
          else if (TIMEOUT != 0 && idle_cnt == IW'(TIMEOUT - 1)) begin
            state <= CLEAN;
            tp <= 1'b1;
          end else idle_cnt <= idle_cnt + IW'(1);
        CLEAN: begin
          addr <= '0;
          bit_cnt <= '0;
          idle_cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // grants, acks and data routing, all forced low while reset is held
  always_comb begin
    live = !rst;
    granted = live && state inside {GRANT, ADDR, CONNECTED};
    conn = live && state == CONNECTED;
    bus.owner = live ? owner : '0;
    bus.timeout_pulse = live && tp;
    bus.m_bgrant = '0;
    bus.m_ack = '0;
    bus.m_slave_ready = '0;
    bus.m_rd_bus = '0;
    bus.m_slave_valid = '0;
    bus.s_mode = '0;
    bus.s_wr_bus = '0;
    bus.s_master_valid = '0;
    bus.s_master_ready = '0;
    for (int j = 0; j < N_MASTERS; j++) begin
      bus.m_bgrant[j] = granted && int'(owner) == j;
      bus.m_ack[j] = conn && int'(owner) == j;
      bus.m_slave_ready[j] = int'(owner) == j && ((live && state == ADDR) || (conn && sready));
      bus.m_rd_bus[j] = conn && int'(owner) == j && rd;
      bus.m_slave_valid[j] = conn && int'(owner) == j && svalid;
    end
    for (int i = 0; i < N_SLAVES; i++) begin
      bus.s_mode[i] = conn && int'(sel) == i && mode;
      bus.s_wr_bus[i] = conn && int'(sel) == i && wr;
      bus.s_master_valid[i] = conn && int'(sel) == i && mvalid;
      bus.s_master_ready[i] = conn && int'(sel) == i && mready;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: randomized traffic against a transaction-level reference of the arbiter
module tb_bus_arbiter_rr;
  localparam int NM = 2, NS = 3, AB = 5, SB = 2, TO = 4;
  logic clk = 0, rst = 1;
  int n_err = 0, n_chk = 0;
  int phase, holder, prev, abits, aval, quiet, target;
  bit tp_exp;
  int cov_to = 0, cov_dec = 0, cov_drop = 0, cov_conn = 0, cov_rst_conn = 0;
  int cov_win[NM];
  bus_arbiter_rr_if #(.N_MASTERS(NM), .N_SLAVES(NS)) bus ();
  bus_arbiter_rr #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_BITS(AB), .SEL_BITS(SB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic bit at(input logic [7:0] v, input int k);
    return ((v >> k) & 8'd1) != 8'd0;
  endfunction
  function automatic int rr_pick(input logic [7:0] req);
    for (int k = 1; k <= NM; k++) if (at(req, (prev + k) % NM)) return (prev + k) % NM;
    return prev;
  endfunction
  task automatic drive(input int p, input int cyc);
    int hi;
    hi = p == 1 ? 10 : 2;
    rst = (p == 0 && cyc < 3) || $urandom_range(0, 119) == 0;
    for (int j = 0; j < NM; j++) begin
      if (p == 3) bus.m_breq[j] = 1'b1;
      else if (bus.m_breq[j]) bus.m_breq[j] = $urandom_range(0, p == 2 ? 3 : 19) != 0;
      else bus.m_breq[j] = $urandom_range(0, 1) == 1;
      bus.m_master_valid[j] = $urandom_range(0, 3) != 0;
      bus.m_mode[j] = $urandom_range(0, 1) == 1;
      bus.m_wr_bus[j] = $urandom_range(0, 1) == 1;
      bus.m_master_ready[j] = $urandom_range(0, hi - 1) == 0;
    end
    for (int i = 0; i < NS; i++) begin
      bus.s_rd_bus[i] = $urandom_range(0, 1) == 1;
      bus.s_slave_ready[i] = $urandom_range(0, hi - 1) == 0;
      bus.s_slave_valid[i] = $urandom_range(0, hi - 1) == 0;
    end
  endtask
  task automatic compare();
    logic [7:0] e_gnt, e_ack, e_srdy, e_rd, e_sv, e_sm, e_sw, e_smv, e_smr;
    bit held;
    {e_gnt, e_ack, e_srdy, e_rd, e_sv, e_sm, e_sw, e_smv, e_smr} = '0;
    held = !rst && phase >= 1 && phase <= 3;
    if (held) begin
      e_gnt = 8'd1 << holder;
      if (phase == 2) e_srdy = e_gnt;
      if (phase == 3) begin
        e_ack = e_gnt;
        if (at(8'(bus.s_slave_ready), target)) e_srdy = e_gnt;
        if (at(8'(bus.s_rd_bus), target)) e_rd = e_gnt;
        if (at(8'(bus.s_slave_valid), target)) e_sv = e_gnt;
        e_sm = 8'(at(8'(bus.m_mode), holder)) << target;
        e_sw = 8'(at(8'(bus.m_wr_bus), holder)) << target;
        e_smv = 8'(at(8'(bus.m_master_valid), holder)) << target;
        e_smr = 8'(at(8'(bus.m_master_ready), holder)) << target;
      end
    end
    chk("bgrant", 8'(bus.m_bgrant), e_gnt);
    chk("ack", 8'(bus.m_ack), e_ack);
    chk("m_slave_ready", 8'(bus.m_slave_ready), e_srdy);
    chk("m_rd_bus", 8'(bus.m_rd_bus), e_rd);
    chk("m_slave_valid", 8'(bus.m_slave_valid), e_sv);
    chk("s_mode", 8'(bus.s_mode), e_sm);
    chk("s_wr_bus", 8'(bus.s_wr_bus), e_sw);
    chk("s_master_valid", 8'(bus.s_master_valid), e_smv);
    chk("s_master_ready", 8'(bus.s_master_ready), e_smr);
    chk("timeout_pulse", 8'(bus.timeout_pulse), 8'(!rst && tp_exp));
    if (rst) chk("owner_rst", 8'(bus.owner), 8'd0);
    else if (held) chk("owner", 8'(bus.owner), 8'(holder));
  endtask
  task automatic model_step();
    logic [7:0] rq;
    bit br, mv, hs;
    rq = 8'(bus.m_breq);
    br = at(rq, holder);
    mv = at(8'(bus.m_master_valid), holder);
    if (rst) begin
      if (phase == 3) cov_rst_conn++;
      phase = 0; holder = 0; prev = NM - 1; abits = 0; aval = 0; quiet = 0; tp_exp = 0;
      return;
    end
    tp_exp = 0;
    case (phase)
      0: if (rq != 0) begin
        holder = rr_pick(rq);
        cov_win[holder]++;
        phase = 1;
      end
      1: if (!br) phase = 0;
        else if (mv) begin
          prev = holder;
          phase = 2;
        end
      2: if (!br) begin
        phase = 4;
        cov_drop++;
      end else if (mv) begin
        aval = aval * 2 + int'(at(8'(bus.m_wr_bus), holder));
        abits++;
        if (abits == AB) begin
          target = aval >> (AB - SB);
          if (target < NS) begin phase = 3; cov_conn++; end
          else begin phase = 4; cov_dec++; end
        end
      end
      3: begin
        hs = (mv && at(8'(bus.s_slave_ready), target)) ||
             (at(8'(bus.s_slave_valid), target) && at(8'(bus.m_master_ready), holder));
        if (!br) phase = 4;
        else if (hs) quiet = 0;
        else if (TO != 0 && quiet + 1 == TO) begin
          phase = 4;
          tp_exp = 1;
          cov_to++;
        end else quiet++;
      end
      default: begin
        phase = 0; aval = 0; abits = 0; quiet = 0;
      end
    endcase
  endtask
  initial begin
    phase = 0; holder = 0; prev = NM - 1; abits = 0; aval = 0; quiet = 0; target = 0; tp_exp = 0;
    for (int j = 0; j < NM; j++) cov_win[j] = 0;
    bus.m_breq = '0; bus.m_mode = '0; bus.m_wr_bus = '0; bus.m_master_valid = '0; bus.m_master_ready = '0;
    bus.s_rd_bus = '0; bus.s_slave_ready = '0; bus.s_slave_valid = '0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk);
        drive(p, c);
        #1 compare();
        @(posedge clk);
        model_step();
      end
    end
    chk("seen_timeout", 8'(cov_to > 0), 8'd1);
    chk("seen_decode_err", 8'(cov_dec > 0), 8'd1);
    chk("seen_addr_drop", 8'(cov_drop > 0), 8'd1);
    chk("seen_connect", 8'(cov_conn > 0), 8'd1);
    chk("seen_rst_connected", 8'(cov_rst_conn > 0), 8'd1);
    chk("seen_win_m0", 8'(cov_win[0] > 0), 8'd1);
    chk("seen_win_m1", 8'(cov_win[1] > 0), 8'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
